// File: rtl/float_to_fixed_normalizer_pkg.sv
// Shared float field constants, FSM states and rounding mode for the
// float-to-fixed normalizer and other float-side blocks.
package float_to_fixed_normalizer_pkg;

   localparam int EXP_BIAS    = 127;
   localparam int MANT_W      = 23;
   localparam int EXP_W       = 8;
   localparam int EXP_SPECIAL = 255;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      SHIFT,
      ROUND,
      DONE
   } state_e;

   typedef enum logic [0:0] {
      RND_HALF_AWAY = 1'b0
   } rnd_mode_e;

   localparam rnd_mode_e RND_MODE = RND_HALF_AWAY;

endpackage

// File: rtl/float_unpack.sv
// Combinational split of an IEEE-754 single into sign, exponent and
// hidden-bit mantissa, with zero/denormal and Inf/NaN class flags.
module float_unpack
   import float_to_fixed_normalizer_pkg::*;
(
   input  logic [31:0]      f,
   output logic             s,
   output logic [EXP_W-1:0] e,
   output logic [MANT_W:0]  mant,
   output logic             is_zero,
   output logic             is_special
);

   assign s          = f[31];
   assign e          = f[MANT_W+EXP_W-1:MANT_W];
   assign mant       = {1'b1, f[MANT_W-1:0]};
   assign is_zero    = (e == '0);
   assign is_special = (e == EXP_W'(EXP_SPECIAL));

endmodule

// File: rtl/float_to_fixed_normalizer.sv
// IEEE-754 single to signed fixed-point (F * 2^SCALE_EXP, FRAC fraction bits).
// FLT2FIX_SAT_EN selects saturation on overflow; otherwise the result wraps.
//
//   state  | meaning
//   IDLE   | waiting for Begin_FSM_FF, captures F
//   UNPACK | split operand, compute shift amount
//   SHIFT  | align mantissa, detect shift overflow, pick round bit
//   ROUND  | round half away from zero, apply sign, flag over/underflow
//   DONE   | publish RESULT/O_F/U_F and pulse ACK_FF
module float_to_fixed_normalizer
   import float_to_fixed_normalizer_pkg::*;
#(
   parameter int P         = 32,
   parameter int FRAC      = 20,
   parameter int SCALE_EXP = 0
) (
   input  logic         CLK,
   input  logic         RST_FF,
   input  logic         Begin_FSM_FF,
   input  logic [31:0]  F,
   output logic         ACK_FF,
   output logic [P-1:0] RESULT,
   output logic         O_F,
   output logic         U_F
);

   localparam logic signed [9:0] SH_OFS = 10'(FRAC + SCALE_EXP - EXP_BIAS - MANT_W);
   localparam logic signed [9:0] SH_MAX = 10'(P - 25);
`ifdef FLT2FIX_SAT_EN
   localparam logic [P-1:0] POS_MAX = {1'b0, {(P-1){1'b1}}};
   localparam logic [P-1:0] NEG_MAX = {1'b1, {(P-1){1'b0}}};
`endif

   state_e              state;
   logic [31:0]         f_r;
   logic                s_r;
   logic                zero_r;
   logic                special_r;
   logic [MANT_W:0]     mant_r;
   logic signed [9:0]   sh_r;
   logic [P-1:0]        mag_r;
   logic                rbit_r;
   logic                ovf_r;
   logic [P-1:0]        res_r;
   logic                of_r;
   logic                uf_r;

   logic                u_s;
   logic [EXP_W-1:0]    u_e;
   logic [MANT_W:0]     u_mant;
   logic                u_zero;
   logic                u_special;
   logic signed [9:0]   sh_calc;
   logic [9:0]          k;
   logic [MANT_W+1:0]   ext_shr;
   logic [P-1:0]        mag_shl;
   logic                rnd_up;
   logic [P-1:0]        mag_rnd;
   logic [P-1:0]        res_nx;
   logic                of_nx;
   logic                uf_nx;

   float_unpack u_unpack (
      .f          (f_r),
      .s          (u_s),
      .e          (u_e),
      .mant       (u_mant),
      .is_zero    (u_zero),
      .is_special (u_special)
   );

   assign sh_calc = $signed({2'b00, u_e}) + SH_OFS;
   assign k       = -sh_r;
   // Bit 0 of the shifted {mant,0} is the first dropped bit; shifts of 25
   // or more leave under half an LSB, so they never round up.
   assign ext_shr = {mant_r, 1'b0} >> k;
   assign mag_shl = P'(mant_r) << sh_r;
   assign rnd_up  = rbit_r && (RND_MODE == RND_HALF_AWAY);
   assign mag_rnd = mag_r + P'(rnd_up);

   always_comb begin
      res_nx = '0;
      of_nx  = 1'b0;
      uf_nx  = 1'b0;
      if (ovf_r || mag_rnd[P-1]) begin
         of_nx = 1'b1;
`ifdef FLT2FIX_SAT_EN
         res_nx = s_r ? NEG_MAX : POS_MAX;
`else
         res_nx = s_r ? -mag_rnd : mag_rnd;
`endif
      end else begin
         res_nx = s_r ? -mag_rnd : mag_rnd;
         uf_nx  = !zero_r && (mag_rnd == '0);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_FF) begin
         state     <= IDLE;
         f_r       <= '0;
         s_r       <= 1'b0;
         zero_r    <= 1'b0;
         special_r <= 1'b0;
         mant_r    <= '0;
         sh_r      <= '0;
         mag_r     <= '0;
         rbit_r    <= 1'b0;
         ovf_r     <= 1'b0;
         res_r     <= '0;
         of_r      <= 1'b0;
         uf_r      <= 1'b0;
         ACK_FF    <= 1'b0;
         RESULT    <= '0;
         O_F       <= 1'b0;
         U_F       <= 1'b0;
      end else begin
         ACK_FF <= 1'b0;
         case (state)
            IDLE: begin
               if (Begin_FSM_FF) begin
                  f_r   <= F;
                  state <= UNPACK;
               end
            end
            UNPACK: begin
               s_r       <= u_s;
               zero_r    <= u_zero;
               special_r <= u_special;
               mant_r    <= u_mant;
               sh_r      <= sh_calc;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (zero_r) begin
                  mag_r  <= '0;
                  rbit_r <= 1'b0;
                  ovf_r  <= 1'b0;
               end else if (special_r) begin
                  mag_r  <= '0;
                  rbit_r <= 1'b0;
                  ovf_r  <= 1'b1;
               end else if (!sh_r[9]) begin
                  // Kept even on overflow: its low P bits are the wrap value.
                  mag_r  <= mag_shl;
                  rbit_r <= 1'b0;
                  ovf_r  <= (sh_r > SH_MAX);
               end else begin
                  mag_r  <= P'(ext_shr[MANT_W+1:1]);
                  rbit_r <= ext_shr[0];
                  ovf_r  <= 1'b0;
               end
               state <= ROUND;
            end
            ROUND: begin
               res_r <= res_nx;
               of_r  <= of_nx;
               uf_r  <= uf_nx;
               state <= DONE;
            end
            DONE: begin
               RESULT <= res_r;
               O_F    <= of_r;
               U_F    <= uf_r;
               ACK_FF <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_fixed_normalizer.sv
// Self-checking bench for float_to_fixed_normalizer against a real-arithmetic
// reference; expectations follow FLT2FIX_SAT_EN when it is defined.
module tb_float_to_fixed_normalizer;

   localparam int P         = 32;
   localparam int FRAC      = 20;
   localparam int SCALE_EXP = 0;

   logic         CLK = 1'b0;
   logic         RST_FF;
   logic         Begin_FSM_FF;
   logic [31:0]  F;
   logic         ACK_FF;
   logic [P-1:0] RESULT;
   logic         O_F;
   logic         U_F;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   float_to_fixed_normalizer #(.P(P), .FRAC(FRAC), .SCALE_EXP(SCALE_EXP)) dut (
      .CLK          (CLK),
      .RST_FF       (RST_FF),
      .Begin_FSM_FF (Begin_FSM_FF),
      .F            (F),
      .ACK_FF       (ACK_FF),
      .RESULT       (RESULT),
      .O_F          (O_F),
      .U_F          (U_F)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Exact value scaled to fixed point, rounded half away from zero.
   function automatic void ref_model(input logic [31:0] f, output logic [P-1:0] r,
                                     output logic of, output logic uf);
      int e;
      real mag, rnd, w;
      logic [P-1:0] m;
      e  = int'(f[30:23]);
      r  = '0;
      of = 1'b0;
      uf = 1'b0;
      if (e == 0) return;
      if (e == 255) begin
         of = 1'b1;
`ifdef FLT2FIX_SAT_EN
         r = f[31] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
`else
         r = '0;
`endif
         return;
      end
      mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127 + FRAC + SCALE_EXP));
      rnd = $floor(mag + 0.5);
      if (rnd >= 2.0 ** (P - 1)) begin
         of = 1'b1;
`ifdef FLT2FIX_SAT_EN
         r = f[31] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
`else
         w = rnd - $floor(rnd / (2.0 ** P)) * (2.0 ** P);
         m = P'(longint'(w));
         r = f[31] ? -m : m;
`endif
      end else begin
         m  = P'(longint'(rnd));
         r  = f[31] ? -m : m;
         uf = (rnd == 0.0);
      end
   endfunction

   function automatic logic [31:0] rand_f(input int e_lo, input int e_hi, input bit allow_spec);
      logic [7:0] e;
      int sel;
      sel = $urandom_range(0, 19);
      if (allow_spec && sel == 0)      e = 8'd0;
      else if (allow_spec && sel == 1) e = 8'd255;
      else                             e = 8'($urandom_range(e_lo, e_hi));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // Drive one start in IDLE; lat = edge count from the start edge to ACK_FF, -1 on timeout.
   task automatic run_conv(input logic [31:0] f, output int lat);
      Begin_FSM_FF = 1'b1;
      F            = f;
      step();
      Begin_FSM_FF = 1'b0;
      F            = $urandom;
      lat          = -1;
      for (int i = 2; i <= 20; i++) begin
         step();
         if (ACK_FF) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST_FF       = 1'b1;
      Begin_FSM_FF = 1'b0;
      F            = 32'h3F80_0000;
      repeat (3) step();
      RST_FF = 1'b0;
      n_cmp++; if (ACK_FF !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ACK_FF); end
      n_cmp++; if (RESULT !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", RESULT); end
      n_cmp++; if (O_F !== 1'b0) begin n_bad++; $display("FAIL reset_of got %b want 0", O_F); end
      n_cmp++; if (U_F !== 1'b0) begin n_bad++; $display("FAIL reset_uf got %b want 0", U_F); end
   endtask

   task automatic test_directed();
      logic [31:0]  tf  [12];
      logic [P-1:0] tr  [12];
      logic         tof [12];
      logic         tuf [12];
      int lat;
      tf = '{32'h3F80_0000, 32'h3F00_0000, 32'hC020_0000, 32'h8000_0000,
             32'h3500_0000, 32'h3480_0000, 32'hB500_0000, 32'h4580_0000,
             32'hC580_0000, 32'h7F80_0000, 32'hFFC0_0000, 32'h0040_0000};
`ifdef FLT2FIX_SAT_EN
      tr = '{32'h0010_0000, 32'h0008_0000, 32'hFFD8_0000, 32'h0,
             32'h1, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
             32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0};
`else
      tr = '{32'h0010_0000, 32'h0008_0000, 32'hFFD8_0000, 32'h0,
             32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0};
`endif
      tof = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
      tuf = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         run_conv(tf[i], lat);
         n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL dir_latency f=%h got %0d want 5", tf[i], lat); end
         n_cmp++; if (RESULT !== tr[i]) begin n_bad++; $display("FAIL dir_result f=%h got %h want %h", tf[i], RESULT, tr[i]); end
         n_cmp++; if (O_F !== tof[i]) begin n_bad++; $display("FAIL dir_of f=%h got %b want %b", tf[i], O_F, tof[i]); end
         n_cmp++; if (U_F !== tuf[i]) begin n_bad++; $display("FAIL dir_uf f=%h got %b want %b", tf[i], U_F, tuf[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0]  f;
      logic [P-1:0] r;
      logic         of, uf;
      int lat;
      for (int i = 0; i < 300; i++) begin
         f = rand_f(98, 142, 1'b1);
         ref_model(f, r, of, uf);
         run_conv(f, lat);
         n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL rnd_latency f=%h got %0d want 5", f, lat); end
         n_cmp++; if (RESULT !== r) begin n_bad++; $display("FAIL rnd_result f=%h got %h want %h", f, RESULT, r); end
         n_cmp++; if (O_F !== of) begin n_bad++; $display("FAIL rnd_of f=%h got %b want %b", f, O_F, of); end
         n_cmp++; if (U_F !== uf) begin n_bad++; $display("FAIL rnd_uf f=%h got %b want %b", f, U_F, uf); end
      end
   endtask

   // Begin held for 10 edges: starts land on edges 0 and 5, ACKs after edges 4 and 9.
   task automatic test_busy();
      logic [31:0]  fs [10];
      logic [P-1:0] r0, r1;
      logic         of, uf;
      int           ack_c [$];
      logic [P-1:0] ack_r [$];
      for (int i = 0; i < 10; i++) fs[i] = rand_f(110, 140, 1'b0);
      for (int c = 0; c < 20; c++) begin
         if (c < 10) begin
            Begin_FSM_FF = 1'b1;
            F            = fs[c];
         end else begin
            Begin_FSM_FF = 1'b0;
         end
         step();
         if (ACK_FF) begin
            ack_c.push_back(c);
            ack_r.push_back(RESULT);
         end
      end
      ref_model(fs[0], r0, of, uf);
      ref_model(fs[5], r1, of, uf);
      n_cmp++; if (ack_c.size() != 2) begin n_bad++; $display("FAIL busy_ack_count got %0d want 2", ack_c.size()); end
      if (ack_c.size() >= 2) begin
         n_cmp++; if (ack_c[0] != 4) begin n_bad++; $display("FAIL busy_ack0_edge got %0d want 4", ack_c[0]); end
         n_cmp++; if (ack_c[1] != 9) begin n_bad++; $display("FAIL busy_ack1_edge got %0d want 9", ack_c[1]); end
         n_cmp++; if (ack_r[0] !== r0) begin n_bad++; $display("FAIL busy_result0 got %h want %h", ack_r[0], r0); end
         n_cmp++; if (ack_r[1] !== r1) begin n_bad++; $display("FAIL busy_result1 got %h want %h", ack_r[1], r1); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]  fa, fb;
      logic [P-1:0] ra, rb;
      logic         ofa, ufa, ofb, ufb;
      int lat;
      fa = rand_f(110, 140, 1'b0);
      fb = rand_f(110, 140, 1'b0);
      ref_model(fa, ra, ofa, ufa);
      ref_model(fb, rb, ofb, ufb);
      run_conv(fa, lat);
      n_cmp++; if (RESULT !== ra) begin n_bad++; $display("FAIL b2b_result_a got %h want %h", RESULT, ra); end
      run_conv(fb, lat);
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL b2b_latency_b got %0d want 5", lat); end
      n_cmp++; if (RESULT !== rb) begin n_bad++; $display("FAIL b2b_result_b got %h want %h", RESULT, rb); end
      n_cmp++; if (O_F !== ofb) begin n_bad++; $display("FAIL b2b_of_b got %b want %b", O_F, ofb); end
   endtask

   task automatic test_reset_mid();
      logic [P-1:0] r;
      logic         of, uf;
      int lat, acks;
      ref_model(32'h4580_0001, r, of, uf);
      run_conv(32'h4580_0001, lat);
      n_cmp++; if (RESULT !== r) begin n_bad++; $display("FAIL pre_reset_result got %h want %h", RESULT, r); end
      n_cmp++; if (O_F !== 1'b1) begin n_bad++; $display("FAIL pre_reset_of got %b want 1", O_F); end
      Begin_FSM_FF = 1'b1;
      F            = 32'hC020_0000;
      step();
      Begin_FSM_FF = 1'b0;
      step();
      RST_FF = 1'b1;
      step();
      RST_FF = 1'b0;
      n_cmp++; if (RESULT !== '0) begin n_bad++; $display("FAIL mid_reset_result got %h want 0", RESULT); end
      n_cmp++; if (O_F !== 1'b0) begin n_bad++; $display("FAIL mid_reset_of got %b want 0", O_F); end
      n_cmp++; if (U_F !== 1'b0) begin n_bad++; $display("FAIL mid_reset_uf got %b want 0", U_F); end
      acks = int'(ACK_FF);
      for (int i = 0; i < 8; i++) begin
         step();
         acks += int'(ACK_FF);
      end
      n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL mid_reset_ack got %0d pulses want 0", acks); end
      run_conv(32'h3F80_0000, lat);
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL post_reset_latency got %0d want 5", lat); end
      n_cmp++; if (RESULT !== 32'h0010_0000) begin n_bad++; $display("FAIL post_reset_result got %h want 00100000", RESULT); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
